// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// Optional divider: define MULDIV_DIV_EN to compile in DIV/DIVU.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nx;
    logic [5:0] cnt;
    logic [2*WIDTH-1:0] acc, step, prod;
    logic [WIDTH-1:0] m, a_mag, b_mag, res_hi, res_lo;
    logic [WIDTH:0] mul_sum;
    logic a_neg, b_neg, neg_res, accept;
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    // acc = {partial product, remaining multiplier bits}; add m when the LSB is set, then shift right
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m & {WIDTH{acc[0]}}};
    assign prod = neg_res ? -acc : acc;
    assign busy = state != IDLE;
`ifdef MULDIV_DIV_EN
    logic is_div, b_zero, neg_a;
    logic [WIDTH:0] shifted, trial;
    logic [2*WIDTH-1:0] step_div;
    // acc = {remainder, dividend/quotient}; shift left one bit and try subtracting the divisor
    assign shifted = acc[2*WIDTH-1:WIDTH-1];
    assign trial = shifted - {1'b0, m};
    assign step_div = trial[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign step = is_div ? step_div : {mul_sum, acc[WIDTH-1:1]};
    // Divide by zero leaves remainder = |a|, which the dividend sign fix turns back into raw a
    assign res_lo = !is_div ? prod[WIDTH-1:0] :
                    b_zero  ? {WIDTH{1'b1}} :
                    neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign res_hi = !is_div ? prod[2*WIDTH-1:WIDTH] :
                    neg_a   ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign accept = start && state == IDLE;
    // Divide-only operation attributes captured at issue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div <= 1'b0;
            b_zero <= 1'b0;
            neg_a  <= 1'b0;
        end else if (accept) begin
            is_div <= op[1];
            b_zero <= b == '0;
            neg_a  <= a_neg;
        end
    end
`else
    assign step = {mul_sum, acc[WIDTH-1:1]};
    assign res_lo = prod[WIDTH-1:0];
    assign res_hi = prod[2*WIDTH-1:WIDTH];
    assign accept = start && state == IDLE && !op[1];
`endif
    // Next-state: IDLE -> RUN on accepted start, RUN -> FIX after the last iteration, FIX -> IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (cnt == 6'(WIDTH-1)) state_nx = FIX;
            default: state_nx = IDLE;
        endcase
    end
    // State register, operand capture and one iteration per RUN cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            m       <= '0;
            neg_res <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt     <= '0;
                neg_res <= a_neg ^ b_neg;
                m       <= op[1] ? b_mag : a_mag;
                acc     <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                acc <= step;
            end
        end
    end
    // HI/LO: result write in FIX, MTHI/MTLO only while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= state == FIX;
            if (state == FIX) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0] op = 2'd0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic busy, done;
    logic [31:0] hi, lo;
    logic [31:0] m_hi = '0, m_lo = '0;
    int n_vec = 0, n_err = 0;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        int q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: return 64'(sx * sy);
            2'd1: return {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit ign, input bit wr);
        logic [63:0] e;
        int nb, nd, nh;
        e = ref_model(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        if (wr) begin
            hi_we = 1'b1; wdata = 32'h12345678; m_hi = 32'h12345678;
        end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; a = $urandom; b = $urandom;
        nb = 0; nd = 0; nh = 0;
        for (int i = 0; i < 33; i++) begin
            nb += int'(busy);
            nd += int'(done);
            if (hi !== m_hi || lo !== m_lo) nh++;
            if (ign && i == 4) begin
                start = 1'b1; op = ~o; a = $urandom; b = $urandom;
                hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
            end
            if (ign && i == 5) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_cycles", nb, 33);
        check("done_early", nd, 0);
        check("hilo_hold", nh, 0);
        m_hi = e[63:32];
        m_lo = e[31:0];
        check("done", {31'd0, done}, 32'd1);
        check("busy_end", {31'd0, busy}, 32'd0);
        check($sformatf("hi op%0d %h,%h", o, x, y), hi, m_hi);
        check($sformatf("lo op%0d %h,%h", o, x, y), lo, m_lo);
    endtask

    initial begin
        int nb, nd, nh;
        logic [1:0] ro;
        logic [31:0] rx, ry;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        hi_we = 1'b0; m_hi = 32'h12345678;
        check("mthi", hi, m_hi);
        check("mthi_lo_kept", lo, m_lo);
        lo_we = 1'b1; wdata = 32'hCAFEF00D;
        @(negedge clk);
        lo_we = 1'b0; m_lo = 32'hCAFEF00D;
        check("mtlo", lo, m_lo);
        do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("multu_hi_const", hi, 32'hFFFFFFFE);
        check("multu_lo_const", lo, 32'h00000001);
        do_op(2'd0, 32'hFFFFFFF9, 32'd6, 1'b1, 1'b0);
        check("mult_lo_const", lo, 32'hFFFFFFD6);
`ifdef MULDIV_DIV_EN
        do_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        check("div_lo_const", lo, 32'hFFFFFFFD);
        check("div_hi_const", hi, 32'hFFFFFFFF);
        do_op(2'd3, 32'd100, 32'd0, 1'b0, 1'b0);
        check("divu0_hi_const", hi, 32'd100);
        do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("divovf_lo_const", lo, 32'h80000000);
        do_op(2'd2, 32'hFFFFFF9C, 32'd0, 1'b0, 1'b0);
`else
        @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        nb = 0; nd = 0; nh = 0;
        for (int i = 0; i < 36; i++) begin
            nb += int'(busy);
            nd += int'(done);
            if (hi !== m_hi || lo !== m_lo) nh++;
            @(negedge clk);
        end
        check("nodiv_busy", nb, 0);
        check("nodiv_done", nd, 0);
        check("nodiv_hilo", nh, 0);
`endif
        @(negedge clk);
        do_op(2'd1, 32'd3, 32'd4, 1'b0, 1'b1);
        do_op(2'd1, 32'd3, 32'd5, 1'b0, 1'b0);
        check("b2b_first", lo, 32'd15);
        do_op(2'd1, 32'd7, 32'd9, 1'b0, 1'b0);
        check("b2b_second", lo, 32'd63);
        for (int k = 0; k < 24; k++) begin
            ro = {DIV_ON & 1'($urandom), 1'($urandom)};
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: ry = 32'd0;
                1: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
                2: begin rx = $urandom_range(0, 300) - 150; ry = $urandom_range(1, 20); end
                default: ;
            endcase
            do_op(ro, rx, ry, 1'($urandom_range(0, 3) == 0), 1'b0);
        end
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'hDEADBEEF; b = 32'h12345;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        m_hi = '0; m_lo = '0;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_hi", hi, m_hi);
        check("arst_lo", lo, m_lo);
        @(negedge clk);
        reset = 1'b0;
        nb = 0; nd = 0; nh = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            nb += int'(busy);
            nd += int'(done);
            if (hi !== m_hi || lo !== m_lo) nh++;
        end
        check("post_rst_busy", nb, 0);
        check("post_rst_done", nd, 0);
        check("post_rst_hilo", nh, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
